// File: rtl/reg_write_arb.sv
// Two-requester write arbiter for a shared register.
// A two-state FSM (IDLE/GRANT) grants one requester per GRANT cycle.
// Contention is resolved round-robin against the last winner.
// The shared register is a bank of per-bit flops, each with an enable mux
// that feeds its own output back when EN is low.
module reg_write_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] D0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             EN,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic [3:0]       WCNT
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic             winner;   // 0 = requester 0, 1 = requester 1
  logic             last;     // winner of the most recent committed write
  logic             pick;     // requester chosen if a grant starts this edge
  logic [WIDTH-1:0] d_sel;    // data presented to the register

  // Both requesting: take the one that did not win last time.
  // Otherwise the single active requester (REQ1 alone -> 1, REQ0 alone -> 0).
  assign pick  = (REQ0 && REQ1) ? ~last : REQ1;
  assign d_sel = winner ? D1 : D0;
  assign BUSY  = (state == GRANT);

  // Arbitration FSM with registered grant/enable outputs and write counter
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state  <= IDLE;
      winner <= 1'b0;
      last   <= 1'b1;
      GNT0   <= 1'b0;
      GNT1   <= 1'b0;
      EN     <= 1'b0;
      WCNT   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ0 || REQ1) begin
            state  <= GRANT;
            winner <= pick;
            GNT0   <= ~pick;
            GNT1   <= pick;
            EN     <= 1'b1;
          end
        end
        GRANT: begin
          // The write commits on this edge; the grant always lasts one cycle.
          state <= IDLE;
          GNT0  <= 1'b0;
          GNT1  <= 1'b0;
          EN    <= 1'b0;
          last  <= winner;
          WCNT  <= WCNT + 4'd1;
        end
        default: begin
          state <= IDLE;
          GNT0  <= 1'b0;
          GNT1  <= 1'b0;
          EN    <= 1'b0;
        end
      endcase
    end
  end

  // Shared register: one enabled flop per bit, holding through feedback
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic bit_q;
    logic bit_d;

    assign bit_d = EN ? d_sel[i] : bit_q;
    assign Q[i]  = bit_q;

    // Per-bit storage element, cleared asynchronously
    always_ff @(posedge clk or posedge CLR) begin
      if (CLR) bit_q <= 1'b0;
      else     bit_q <= bit_d;
    end
  end

endmodule

// File: tb/tb_reg_write_arb.sv
// Bench for reg_write_arb: directed scenarios with literal expectations,
// then randomized requesters, all checked every cycle against a
// transaction-level model of the arbiter.
module tb_reg_write_arb;

  logic       clk = 1'b0;
  logic       CLR = 1'b1;
  logic       REQ0 = 1'b0;
  logic       REQ1 = 1'b0;
  logic [7:0] D0 = 8'h00;
  logic [7:0] D1 = 8'h00;
  logic       GNT0, GNT1, EN, BUSY;
  logic [7:0] Q;
  logic [3:0] WCNT;

  int total = 0;
  int bad   = 0;

  reg_write_arb #(.WIDTH(8)) dut (
    .clk(clk), .CLR(CLR),
    .REQ0(REQ0), .D0(D0), .REQ1(REQ1), .D1(D1),
    .GNT0(GNT0), .GNT1(GNT1), .EN(EN), .Q(Q), .BUSY(BUSY), .WCNT(WCNT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // pend: requester holding a grant this cycle (-1 = none).
  int         m_pend = -1;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_q    = 8'h00;
  int         m_cnt  = 0;
  int         m_last = 1;

  always @(posedge clk or posedge CLR) begin
    int w;
    if (CLR) begin
      m_pend <= -1;
      m_q    <= 8'h00;
      m_cnt  <= 0;
      m_last <= 1;
    end else if (m_pend >= 0) begin
      m_q    <= m_data;
      m_cnt  <= (m_cnt + 1) % 16;
      m_last <= m_pend;
      m_pend <= -1;
    end else if (REQ0 || REQ1) begin
      if (REQ0 && REQ1) w = (m_last == 0) ? 1 : 0;  // the one that did not go last
      else              w = REQ1 ? 1 : 0;
      m_pend <= w;
      m_data <= (w == 1) ? D1 : D0;
    end
  end

  bit cmp_on = 1'b0;

  // every-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_on && !CLR) begin
      chk("gnt0", GNT0, (m_pend == 0));
      chk("gnt1", GNT1, (m_pend == 1));
      chk("en",   EN,   (m_pend >= 0));
      chk("busy", BUSY, (m_pend >= 0));
      chk("q",    Q,    m_q);
      chk("wcnt", WCNT, m_cnt[3:0]);
      chk("excl", GNT0 & GNT1, 1'b0);
    end
  end

  task automatic do_reset();
    REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge clk);
    CLR = 1'b1;
    @(negedge clk);
    CLR = 1'b0;
  endtask

  // single write from requester r with data d; returns after the commit edge
  task automatic single_write(input int r, input logic [7:0] d);
    if (r == 0) begin REQ0 = 1'b1; D0 = d; end
    else        begin REQ1 = 1'b1; D1 = d; end
    @(negedge clk);
    if (r == 0) begin chk("sw_gnt0", GNT0, 1'b1); REQ0 = 1'b0; end
    else        begin chk("sw_gnt1", GNT1, 1'b1); REQ1 = 1'b0; end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] lastd;
    int seq [$];
    logic gseen0, gseen1;

    // reset state while CLR held
    #2;
    chk("rst_gnt0", GNT0, 1'b0);
    chk("rst_gnt1", GNT1, 1'b0);
    chk("rst_en",   EN,   1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_q",    Q,    8'h00);
    chk("rst_wcnt", WCNT, 4'd0);
    @(negedge clk);
    CLR = 1'b0;
    cmp_on = 1'b1;

    // single write A5 from requester 0
    REQ0 = 1'b1; D0 = 8'hA5;
    @(negedge clk);
    chk("a5_gnt0", GNT0, 1'b1);
    chk("a5_en",   EN,   1'b1);
    chk("a5_gnt1", GNT1, 1'b0);
    REQ0 = 1'b0;
    @(negedge clk);
    chk("a5_q",    Q,    8'hA5);
    chk("a5_wcnt", WCNT, 4'd1);
    chk("a5_en0",  EN,   1'b0);

    // both from reset: 0 first, then 1 two cycles later
    do_reset();
    REQ0 = 1'b1; REQ1 = 1'b1; D0 = 8'h11; D1 = 8'h22;
    @(negedge clk);
    chk("both_gnt0", GNT0, 1'b1);
    chk("both_gnt1a", GNT1, 1'b0);
    REQ0 = 1'b0;
    @(negedge clk);
    chk("both_q11", Q, 8'h11);
    chk("both_idle", BUSY, 1'b0);
    @(negedge clk);
    chk("both_gnt1", GNT1, 1'b1);
    REQ1 = 1'b0;
    @(negedge clk);
    chk("both_q22", Q, 8'h22);
    chk("both_wcnt", WCNT, 4'd2);

    // continuous contention: 8 grants alternate
    do_reset();
    REQ0 = 1'b1; REQ1 = 1'b1; D0 = 8'h5A; D1 = 8'hC3;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (GNT0) seq.push_back(0);
      if (GNT1) seq.push_back(1);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    chk("alt_count", seq.size(), 8);
    for (int i = 0; i < seq.size(); i++) chk("alt_order", seq[i], i % 2);
    chk("alt_wcnt", WCNT, 4'd8);

    // 17 writes from requester 1: counter wraps to 1
    do_reset();
    lastd = 8'h00;
    for (int i = 0; i < 17; i++) begin
      lastd = 8'($urandom);
      single_write(1, lastd);
    end
    chk("wrap_wcnt", WCNT, 4'd1);
    chk("wrap_q", Q, lastd);

    // idle hold after writing 3C
    single_write(0, 8'h3C);
    for (int i = 0; i < 10; i++) begin
      chk("hold_q", Q, 8'h3C);
      chk("hold_en", EN, 1'b0);
      chk("hold_busy", BUSY, 1'b0);
      @(negedge clk);
    end

    // asynchronous clear during a GRANT to requester 1
    do_reset();
    single_write(0, 8'h77);          // last winner now requester 0
    REQ1 = 1'b1; D1 = 8'hFF;
    @(negedge clk);
    chk("clr_pre_gnt1", GNT1, 1'b1);
    #2 CLR = 1'b1;
    #1;
    chk("clr_gnt1", GNT1, 1'b0);
    chk("clr_en",   EN,   1'b0);
    chk("clr_busy", BUSY, 1'b0);
    chk("clr_q",    Q,    8'h00);
    chk("clr_wcnt", WCNT, 4'd0);
    @(negedge clk);
    CLR = 1'b0;
    REQ0 = 1'b1; D0 = 8'h44;          // REQ1 still high: contention
    @(negedge clk);
    chk("clr_after_gnt0", GNT0, 1'b1);
    chk("clr_after_gnt1", GNT1, 1'b0);
    REQ0 = 1'b0;
    @(negedge clk);
    chk("clr_after_q", Q, 8'h44);
    @(negedge clk);
    REQ1 = 1'b0;
    @(negedge clk);

    // randomized requesters
    gseen0 = 1'b0; gseen1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (GNT0) REQ0 = 1'b0;
      else if (!REQ0 && $urandom_range(0, 2) != 0) begin REQ0 = 1'b1; D0 = 8'($urandom); end
      if (GNT1) REQ1 = 1'b0;
      else if (!REQ1 && $urandom_range(0, 2) != 0) begin REQ1 = 1'b1; D1 = 8'($urandom); end
      if (c == 300) begin
        #3 CLR = 1'b1;
        #1 CLR = 1'b0;
        REQ0 = 1'b0; REQ1 = 1'b0;
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (3) @(negedge clk);

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
